// File: rtl/multicycle_ctrl.sv
// Moore FSM control unit for the multi-cycle MIPS datapath (shared ALU, single memory, IR/A/B/ALUOut).
// Latency (memory always ready): R/addi/slti 4 cycles, lw 5, sw 4, beq 3, j 3.
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ready_i; TIMEOUT consecutive waits -> sticky HALT.
//
// Ports: clk_i/rst_i (async active-low) clock and reset; instr_op_i IR[31:26]; mem_ready_i memory
//   completion; datapath strobes/selects PCWrite_o .. RegDst_o; illegal_o one-cycle unknown-opcode
//   pulse in DECODE; fault_o memory-timeout flag; state_o current state code.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       MemtoReg_o,
    output logic       IRWrite_o,
    output logic [1:0] PCSource_o,
    output logic [2:0] ALU_op_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic       RegWrite_o,
    output logic       RegDst_o,
    output logic       illegal_o,
    output logic       fault_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_RST      = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam int            CW    = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait;
    logic          w_is_wait;
    logic          w_timeout;

    assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // A ready on the final allowed cycle still completes normally.
    assign w_timeout = w_is_wait && !mem_ready_i && (r_wait == LIMIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Counts consecutive not-ready cycles within one memory-wait state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_is_wait && !mem_ready_i) begin
            r_wait <= r_wait + CW'(1);
        end
    end

    always_comb begin
        w_next        = r_state;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        MemtoReg_o    = 1'b0;
        IRWrite_o     = 1'b0;
        PCSource_o    = 2'b00;
        ALU_op_o      = 3'b000;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        RegWrite_o    = 1'b0;
        RegDst_o      = 1'b0;
        illegal_o     = 1'b0;

        case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                ALU_op_o  = 3'b010;
                // IR and PC+4 commit only once the instruction word is actually delivered.
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
                if (mem_ready_i) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB_o = 2'b11;
                ALU_op_o  = 3'b010;
                case (instr_op_i)
                    OP_R:             w_next = S_R_EXEC;
                    OP_LW, OP_SW:     w_next = S_MEM_ADDR;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    OP_ADDI, OP_SLTI: w_next = S_I_EXEC;
                    default: begin
                        w_next    = S_FETCH;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = 3'b010;
                w_next    = (instr_op_i == OP_SW) ? S_MEM_WR :
                            (instr_op_i == OP_LW) ? S_MEM_RD : S_FETCH;
            end
            S_MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                if (mem_ready_i) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                if (mem_ready_i) w_next = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA_o = 1'b1;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALU_op_o      = 3'b110;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'b10;
                w_next     = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = (instr_op_i == OP_SLTI) ? 3'b111 : 3'b010;
                w_next    = S_I_WB;
            end
            S_I_WB: begin
                RegWrite_o = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RST;
        endcase

        if (w_timeout) w_next = S_HALT;
    end

    // HALT is left only through reset, so the state itself is the sticky flag.
    assign fault_o = (r_state == S_HALT);
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       mem_ready_i;
    logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, MemtoReg_o, IRWrite_o;
    logic [1:0] PCSource_o;
    logic [2:0] ALU_op_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic       RegWrite_o, RegDst_o, illegal_o, fault_o;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o),
        .IRWrite_o(IRWrite_o), .PCSource_o(PCSource_o), .ALU_op_o(ALU_op_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .RegWrite_o(RegWrite_o),
        .RegDst_o(RegDst_o), .illegal_o(illegal_o), .fault_o(fault_o), .state_o(state_o)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite}, PCSource, ALU_op, ALUSrcA, ALUSrcB, {RegWrite,RegDst}
    wire [16:0] ctl = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, MemtoReg_o, IRWrite_o,
                       PCSource_o, ALU_op_o, ALUSrcA_o, ALUSrcB_o, RegWrite_o, RegDst_o};

    localparam logic [16:0] C_ZERO   = 17'd0;
    localparam logic [16:0] C_FET_R1 = {7'b1001001, 2'b00, 3'b010, 1'b0, 2'b01, 2'b00};
    localparam logic [16:0] C_FET_R0 = {7'b0001000, 2'b00, 3'b010, 1'b0, 2'b01, 2'b00};
    localparam logic [16:0] C_DEC    = {7'b0000000, 2'b00, 3'b010, 1'b0, 2'b11, 2'b00};
    localparam logic [16:0] C_MADDR  = {7'b0000000, 2'b00, 3'b010, 1'b1, 2'b10, 2'b00};
    localparam logic [16:0] C_MRD    = {7'b0011000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};
    localparam logic [16:0] C_MWB    = {7'b0000010, 2'b00, 3'b000, 1'b0, 2'b00, 2'b10};
    localparam logic [16:0] C_MWR    = {7'b0010100, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00};
    localparam logic [16:0] C_REXE   = {7'b0000000, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00};
    localparam logic [16:0] C_RWB    = {7'b0000000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b11};
    localparam logic [16:0] C_BR     = {7'b0100000, 2'b01, 3'b110, 1'b1, 2'b00, 2'b00};
    localparam logic [16:0] C_JMP    = {7'b1000000, 2'b10, 3'b000, 1'b0, 2'b00, 2'b00};
    localparam logic [16:0] C_ADDI   = {7'b0000000, 2'b00, 3'b010, 1'b1, 2'b10, 2'b00};
    localparam logic [16:0] C_SLTI   = {7'b0000000, 2'b00, 3'b111, 1'b1, 2'b10, 2'b00};
    localparam logic [16:0] C_IWB    = {7'b0000000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b10};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are already set; let them settle, check the current state's outputs, then clock once.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c, input logic ill);
        #2;
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".ctl"}, 32'(ctl), 32'(c));
        check({tag, ".illegal"}, 32'(illegal_o), 32'(ill));
        check({tag, ".fault"}, 32'(fault_o), 32'(st == 4'd15));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b0;
        instr_op_i  = 6'b000000;
        mem_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        cyc("reset", 4'd14, C_ZERO, 1'b0);
        rst_i = 1'b1;
        cyc("rst_release", 4'd14, C_ZERO, 1'b0);

        // lw with memory always ready
        instr_op_i = 6'b100011; mem_ready_i = 1'b1;
        cyc("lw.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("lw.decode", 4'd1, C_DEC, 1'b0);
        cyc("lw.addr", 4'd2, C_MADDR, 1'b0);
        cyc("lw.rd", 4'd3, C_MRD, 1'b0);
        cyc("lw.wb", 4'd4, C_MWB, 1'b0);

        instr_op_i = 6'b101011;
        cyc("sw.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("sw.decode", 4'd1, C_DEC, 1'b0);
        cyc("sw.addr", 4'd2, C_MADDR, 1'b0);
        cyc("sw.wr", 4'd5, C_MWR, 1'b0);

        instr_op_i = 6'b000000;
        cyc("r.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("r.decode", 4'd1, C_DEC, 1'b0);
        cyc("r.exec", 4'd6, C_REXE, 1'b0);
        cyc("r.wb", 4'd7, C_RWB, 1'b0);

        instr_op_i = 6'b000100;
        cyc("beq.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("beq.decode", 4'd1, C_DEC, 1'b0);
        cyc("beq.branch", 4'd8, C_BR, 1'b0);

        instr_op_i = 6'b000010;
        cyc("j.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("j.decode", 4'd1, C_DEC, 1'b0);
        cyc("j.jump", 4'd9, C_JMP, 1'b0);

        instr_op_i = 6'b001000;
        cyc("addi.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("addi.decode", 4'd1, C_DEC, 1'b0);
        cyc("addi.exec", 4'd10, C_ADDI, 1'b0);
        cyc("addi.wb", 4'd11, C_IWB, 1'b0);

        instr_op_i = 6'b001010;
        cyc("slti.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("slti.decode", 4'd1, C_DEC, 1'b0);
        cyc("slti.exec", 4'd10, C_SLTI, 1'b0);
        cyc("slti.wb", 4'd11, C_IWB, 1'b0);

        // FETCH stalls three cycles, ready on the fourth
        instr_op_i = 6'b000000; mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) cyc("fetch_wait", 4'd0, C_FET_R0, 1'b0);
        mem_ready_i = 1'b1;
        cyc("fetch_go", 4'd0, C_FET_R1, 1'b0);
        cyc("fetch_wait.decode", 4'd1, C_DEC, 1'b0);
        cyc("fetch_wait.exec", 4'd6, C_REXE, 1'b0);
        cyc("fetch_wait.wb", 4'd7, C_RWB, 1'b0);

        // Unknown opcode: one-cycle pulse, back to FETCH, no writes
        instr_op_i = 6'b111111;
        cyc("ill.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("ill.decode", 4'd1, C_DEC, 1'b1);
        instr_op_i = 6'b101011;
        cyc("ill.next", 4'd0, C_FET_R1, 1'b0);

        // sw: ready arrives on the last allowed wait cycle -> no fault
        cyc("swlate.decode", 4'd1, C_DEC, 1'b0);
        cyc("swlate.addr", 4'd2, C_MADDR, 1'b0);
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) cyc("swlate.wait", 4'd5, C_MWR, 1'b0);
        mem_ready_i = 1'b1;
        cyc("swlate.done", 4'd5, C_MWR, 1'b0);

        // lw interrupted by reset during MEM_RD
        instr_op_i = 6'b100011;
        cyc("lwrst.fetch", 4'd0, C_FET_R1, 1'b0);
        cyc("lwrst.decode", 4'd1, C_DEC, 1'b0);
        cyc("lwrst.addr", 4'd2, C_MADDR, 1'b0);
        mem_ready_i = 1'b0;
        #2;
        check("lwrst.in_rd", 32'(state_o), 32'd3);
        rst_i = 1'b0;
        #1;
        check("lwrst.async_state", 32'(state_o), 32'd14);
        check("lwrst.async_ctl", 32'(ctl), 32'(C_ZERO));
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cyc("lwrst.rst_cycle", 4'd14, C_ZERO, 1'b0);
        mem_ready_i = 1'b1;
        cyc("lwrst.refetch", 4'd0, C_FET_R1, 1'b0);

        // sw with memory never ready -> HALT after 4 wait cycles
        instr_op_i = 6'b101011;
        cyc("swto.decode", 4'd1, C_DEC, 1'b0);
        cyc("swto.addr", 4'd2, C_MADDR, 1'b0);
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc("swto.wait", 4'd5, C_MWR, 1'b0);
        cyc("swto.halt", 4'd15, C_ZERO, 1'b0);
        mem_ready_i = 1'b1;
        cyc("swto.halt_sticky", 4'd15, C_ZERO, 1'b0);
        rst_i = 1'b0;
        #1;
        check("swto.reset_clears", 32'(fault_o), 32'd0);
        check("swto.reset_state", 32'(state_o), 32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
